// File: rtl/mul_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: 32-cycle shift-add multiply and
// restoring divide, plus MTHI/MTLO writes while idle.
module mul_div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  operation,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic        hiWrite,
    input  logic        loWrite,
    input  logic [31:0] writeData,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;

    logic [1:0]  state;
    logic [4:0]  counter;
    logic [31:0] multiplicand;
    logic [63:0] acc;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        resultNeg;
    logic        remNeg;
    logic [31:0] hiReg;
    logic [31:0] loReg;
    logic        doneReg;

    logic        isSigned;
    logic        divByZero;
    logic        lastIter;
    logic [31:0] absA;
    logic [31:0] absB;
    logic [32:0] mulSum;
    logic [63:0] accNext;
    logic [63:0] product;
    logic [32:0] shifted;
    logic        fits;
    logic [31:0] remNext;
    logic [31:0] quotNext;
    logic [31:0] quotOut;
    logic [31:0] remOut;

    always_comb begin
        isSigned  = ~operation[0];
        divByZero = (operandB == 32'd0);
        lastIter  = (counter == 5'd31);
        absA      = operandA[31] ? -operandA : operandA;
        absB      = operandB[31] ? -operandB : operandB;

        // Shift-add: add multiplicand into the top half when the current multiplier bit is set.
        mulSum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, multiplicand} : 33'd0);
        accNext = {mulSum, acc[31:1]};
        product = resultNeg ? -accNext : accNext;

        // Restoring step on the 33-bit partial remainder; the difference always fits in 32 bits.
        shifted  = {remainder, quotient[31]};
        fits     = (shifted >= {1'b0, divisor});
        remNext  = shifted[31:0] - (fits ? divisor : 32'd0);
        quotNext = {quotient[30:0], fits};
        quotOut  = resultNeg ? -quotNext : quotNext;
        remOut   = remNeg ? -remNext : remNext;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            counter      <= 5'd0;
            multiplicand <= 32'd0;
            acc          <= 64'd0;
            divisor      <= 32'd0;
            quotient     <= 32'd0;
            remainder    <= 32'd0;
            resultNeg    <= 1'b0;
            remNeg       <= 1'b0;
            hiReg        <= 32'd0;
            loReg        <= 32'd0;
            doneReg      <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        counter <= 5'd0;
                        if (operation[1]) begin
                            state     <= DIV;
                            // Divide by zero runs unsigned so the dividend emerges unchanged in hi.
                            quotient  <= (isSigned && !divByZero) ? absA : operandA;
                            divisor   <= isSigned ? absB : operandB;
                            remainder <= 32'd0;
                            resultNeg <= isSigned && !divByZero && (operandA[31] ^ operandB[31]);
                            remNeg    <= isSigned && !divByZero && operandA[31];
                        end else begin
                            state        <= MUL;
                            multiplicand <= isSigned ? absA : operandA;
                            acc          <= {32'd0, (isSigned ? absB : operandB)};
                            resultNeg    <= isSigned && (operandA[31] ^ operandB[31]);
                            remNeg       <= 1'b0;
                        end
                    end else begin
                        if (hiWrite) hiReg <= writeData;
                        if (loWrite) loReg <= writeData;
                    end
                end
                MUL: begin
                    acc     <= accNext;
                    counter <= counter + 5'd1;
                    if (lastIter) begin
                        state   <= IDLE;
                        hiReg   <= product[63:32];
                        loReg   <= product[31:0];
                        doneReg <= 1'b1;
                    end
                end
                DIV: begin
                    remainder <= remNext;
                    quotient  <= quotNext;
                    counter   <= counter + 5'd1;
                    if (lastIter) begin
                        state   <= IDLE;
                        hiReg   <= remOut;
                        loReg   <= quotOut;
                        doneReg <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = doneReg;
    assign hi   = hiReg;
    assign lo   = loReg;

endmodule
